// File: rtl/controller_fsm.sv
// controller_fsm -- multicycle instruction sequencer for a small ARM-like datapath.
//
// Steps each instruction through fetch, decode and one to three execute states.
// It drives the datapath enables, mux selects and ALU function from the current
// state and IR. It also holds the condition flags used by the decode step.
//
// Ports
//   clk                      sole clock, rising edge
//   reset                    synchronous, active-high
//   IR[31:0]                 instruction register from the datapath
//   Z, C, N, V               live ALU flags
//   Mem_read, Mem_write, reg_write, PC_write, Jump, ldPCreg, IRwrite   enables
//   IoD, PCreg, WAddr, DT_store, ALUsrcA, PCsrc                        mux selects
//   ALUsrcB[1:0]             00 B, 01 const 1, 10 OP2 imm, 11 sext26
//   writeMux[1:0]            00 MDR, 01 ALU_out, 10 PC
//   ALUoperation[3:0]        ALU function
//   flags[3:0]               latched {N,Z,C,V}
//   state[3:0]               current state encoding
//
// state    | meaning
// ---------+----------------------------------------------------------
// FETCH    | read instruction, PC <= PC + 1
// DECODE   | test condition field against latched flags, dispatch
// EXEC_DP  | data-processing ALU op, optional flag update
// WB_DP    | write ALU result to register file
// MEM_ADDR | compute load/store address (base +/- offset)
// MEM_RD   | read data memory
// MEM_WB   | write loaded data to register file
// MEM_ST   | write data memory
// BRANCH   | PC <= PC + sext26, optional link write of PC

module controller_fsm #(
   parameter logic [3:0] ALU_ADD = 4'b0100,
   parameter logic [3:0] ALU_SUB = 4'b0010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR,
   input  logic        Z,
   input  logic        C,
   input  logic        N,
   input  logic        V,
   output logic        Mem_read,
   output logic        Mem_write,
   output logic        reg_write,
   output logic        PC_write,
   output logic        Jump,
   output logic        ldPCreg,
   output logic        IRwrite,
   output logic        IoD,
   output logic        PCreg,
   output logic        WAddr,
   output logic        DT_store,
   output logic        ALUsrcA,
   output logic        PCsrc,
   output logic [1:0]  ALUsrcB,
   output logic [1:0]  writeMux,
   output logic [3:0]  ALUoperation,
   output logic [3:0]  flags,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_DP  = 4'd2,
      S_WB_DP    = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_ST   = 4'd7,
      S_BRANCH   = 4'd8
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_flags;
   logic       w_cond;
   logic       w_flag_ld;
   logic       w_unused;

   // Offset/register fields are consumed by the datapath, not here.
   assign w_unused = ^{IR[19:0]};

   assign state = r_state;
   assign flags = r_flags;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_flags <= 4'b0000;
      end else begin
         r_state <= w_next;
         if (w_flag_ld) r_flags <= {N, Z, C, V};
      end
   end

   // Condition field against the latched flags, r_flags = {N,Z,C,V}.
   always_comb begin
      w_cond = 1'b0;
      case (IR[31:28])
         4'h0: w_cond = r_flags[2];
         4'h1: w_cond = !r_flags[2];
         4'h2: w_cond = r_flags[1];
         4'h3: w_cond = !r_flags[1];
         4'h4: w_cond = r_flags[3];
         4'h5: w_cond = !r_flags[3];
         4'h6: w_cond = r_flags[0];
         4'h7: w_cond = !r_flags[0];
         4'h8: w_cond = r_flags[1] && !r_flags[2];
         4'h9: w_cond = !r_flags[1] || r_flags[2];
         4'hA: w_cond = (r_flags[3] == r_flags[0]);
         4'hB: w_cond = (r_flags[3] != r_flags[0]);
         4'hC: w_cond = !r_flags[2] && (r_flags[3] == r_flags[0]);
         4'hD: w_cond = r_flags[2] || (r_flags[3] != r_flags[0]);
         default: w_cond = 1'b1;
      endcase
   end

   always_comb begin
      w_next       = S_FETCH;
      w_flag_ld    = 1'b0;
      Mem_read     = 1'b0;
      Mem_write    = 1'b0;
      reg_write    = 1'b0;
      PC_write     = 1'b0;
      Jump         = 1'b0;
      ldPCreg      = 1'b0;
      IRwrite      = 1'b0;
      IoD          = 1'b0;
      PCreg        = 1'b0;
      WAddr        = 1'b0;
      DT_store     = 1'b0;
      ALUsrcA      = 1'b0;
      PCsrc        = 1'b0;
      ALUsrcB      = 2'b00;
      writeMux     = 2'b00;
      ALUoperation = 4'b0000;

      case (r_state)
         S_FETCH: begin
            Mem_read     = 1'b1;
            IRwrite      = 1'b1;
            ldPCreg      = 1'b1;
            PC_write     = 1'b1;
            ALUsrcB      = 2'b01;
            ALUoperation = ALU_ADD;
            w_next       = S_DECODE;
         end
         S_DECODE: begin
            if (w_cond) begin
               case (IR[27:26])
                  2'b00:   w_next = S_EXEC_DP;
                  2'b01:   w_next = S_MEM_ADDR;
                  2'b10:   w_next = S_BRANCH;
                  default: w_next = S_FETCH;
               endcase
            end
         end
         S_EXEC_DP: begin
            ALUsrcA      = 1'b1;
            ALUsrcB      = IR[25] ? 2'b10 : 2'b00;
            ALUoperation = IR[24:21];
            w_flag_ld    = IR[20];
            // TST and CMP only set flags, so they skip write-back.
            if (IR[24:21] == 4'b1000 || IR[24:21] == 4'b1010) w_next = S_FETCH;
            else                                               w_next = S_WB_DP;
         end
         S_WB_DP: begin
            reg_write = 1'b1;
            writeMux  = 2'b01;
         end
         S_MEM_ADDR: begin
            ALUsrcA      = 1'b1;
            ALUsrcB      = 2'b10;
            ALUoperation = IR[23] ? ALU_ADD : ALU_SUB;
            w_next       = IR[20] ? S_MEM_RD : S_MEM_ST;
         end
         S_MEM_RD: begin
            Mem_read = 1'b1;
            IoD      = 1'b1;
            w_next   = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write = 1'b1;
         end
         S_MEM_ST: begin
            Mem_write = 1'b1;
            IoD       = 1'b1;
            DT_store  = 1'b1;
         end
         S_BRANCH: begin
            PCreg        = 1'b1;
            ALUsrcB      = 2'b11;
            ALUoperation = ALU_ADD;
            Jump         = 1'b1;
            if (IR[24]) begin
               reg_write = 1'b1;
               WAddr     = 1'b1;
               writeMux  = 2'b10;
            end
         end
         default: w_next = S_FETCH;
      endcase

      // Reset blanks every control output immediately so an aborted
      // instruction cannot complete a write in the reset cycle.
      if (reset) begin
         Mem_read     = 1'b0;
         Mem_write    = 1'b0;
         reg_write    = 1'b0;
         PC_write     = 1'b0;
         Jump         = 1'b0;
         ldPCreg      = 1'b0;
         IRwrite      = 1'b0;
         IoD          = 1'b0;
         PCreg        = 1'b0;
         WAddr        = 1'b0;
         DT_store     = 1'b0;
         ALUsrcA      = 1'b0;
         PCsrc        = 1'b0;
         ALUsrcB      = 2'b00;
         writeMux     = 2'b00;
         ALUoperation = 4'b0000;
      end
   end

endmodule

// File: tb/tb_controller_fsm.sv
module tb_controller_fsm;

   localparam logic [3:0] ADD = 4'b0100;
   localparam logic [3:0] SUB = 4'b0010;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IR;
   logic        Z, C, N, V;
   logic        Mem_read, Mem_write, reg_write, PC_write, Jump, ldPCreg, IRwrite;
   logic        IoD, PCreg, WAddr, DT_store, ALUsrcA, PCsrc;
   logic [1:0]  ALUsrcB, writeMux;
   logic [3:0]  ALUoperation, flags, state;

   controller_fsm dut (
      .clk(clk), .reset(reset), .IR(IR), .Z(Z), .C(C), .N(N), .V(V),
      .Mem_read(Mem_read), .Mem_write(Mem_write), .reg_write(reg_write),
      .PC_write(PC_write), .Jump(Jump), .ldPCreg(ldPCreg), .IRwrite(IRwrite),
      .IoD(IoD), .PCreg(PCreg), .WAddr(WAddr), .DT_store(DT_store),
      .ALUsrcA(ALUsrcA), .PCsrc(PCsrc), .ALUsrcB(ALUsrcB), .writeMux(writeMux),
      .ALUoperation(ALUoperation), .flags(flags), .state(state)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] mflags;
   int         exp_q[$];
   logic [20:0] dut_out;

   assign dut_out = {Mem_read, Mem_write, reg_write, PC_write, Jump, ldPCreg, IRwrite,
                     IoD, PCreg, WAddr, DT_store, ALUsrcA, PCsrc,
                     ALUsrcB, writeMux, ALUoperation};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
      logic fn, fz, fc, fv;
      {fn, fz, fc, fv} = f;
      case (cc)
         4'h0: return fz;
         4'h1: return !fz;
         4'h2: return fc;
         4'h3: return !fc;
         4'h4: return fn;
         4'h5: return !fn;
         4'h6: return fv;
         4'h7: return !fv;
         4'h8: return fc && !fz;
         4'h9: return !fc || fz;
         4'hA: return fn == fv;
         4'hB: return fn != fv;
         4'hC: return !fz && (fn == fv);
         4'hD: return fz || (fn != fv);
         default: return 1'b1;
      endcase
   endfunction

   // Expected control outputs for one visited state, straight from the
   // per-state output table; everything not listed stays 0.
   function automatic logic [20:0] expect_out(input int st, input logic [31:0] ir);
      logic mr, mw, rw, pcw, jmp, ldpc, irw, iod, pcr, wa, dts, sra, pcs;
      logic [1:0] srb, wm;
      logic [3:0] op;
      {mr, mw, rw, pcw, jmp, ldpc, irw, iod, pcr, wa, dts, sra, pcs} = '0;
      srb = 2'b00; wm = 2'b00; op = 4'b0000;
      if (st == 0) begin mr = 1; irw = 1; ldpc = 1; pcw = 1; srb = 2'b01; op = ADD; end
      if (st == 2) begin sra = 1; srb = ir[25] ? 2'b10 : 2'b00; op = ir[24:21]; end
      if (st == 3) begin rw = 1; wm = 2'b01; end
      if (st == 4) begin sra = 1; srb = 2'b10; op = ir[23] ? ADD : SUB; end
      if (st == 5) begin mr = 1; iod = 1; end
      if (st == 6) begin rw = 1; wm = 2'b00; end
      if (st == 7) begin mw = 1; iod = 1; dts = 1; end
      if (st == 8) begin
         pcr = 1; srb = 2'b11; op = ADD; jmp = 1;
         if (ir[24]) begin rw = 1; wa = 1; wm = 2'b10; end
      end
      return {mr, mw, rw, pcw, jmp, ldpc, irw, iod, pcr, wa, dts, sra, pcs, srb, wm, op};
   endfunction

   // Instruction class -> list of visited states.
   task automatic plan(input logic [31:0] ir, input logic [3:0] f);
      exp_q.delete();
      exp_q.push_back(0);
      exp_q.push_back(1);
      if (cond_ok(ir[31:28], f)) begin
         if (ir[27:26] == 2'b00) begin
            exp_q.push_back(2);
            if (!(ir[24:21] == 4'b1000 || ir[24:21] == 4'b1010)) exp_q.push_back(3);
         end else if (ir[27:26] == 2'b01) begin
            exp_q.push_back(4);
            if (ir[20]) begin exp_q.push_back(5); exp_q.push_back(6); end
            else exp_q.push_back(7);
         end else if (ir[27:26] == 2'b10) begin
            exp_q.push_back(8);
         end
      end
   endtask

   // Called at a point where the DUT sits in FETCH (between edges).
   task automatic run_instr(input string tag, input logic [31:0] ir,
                            input logic z, input logic c, input logic n, input logic v);
      logic       upd;
      logic [3:0] nf;
      IR = ir; Z = z; C = c; N = n; V = v;
      #1;
      plan(ir, mflags);
      upd = cond_ok(ir[31:28], mflags) && ir[27:26] == 2'b00 && ir[20];
      nf  = {n, z, c, v};
      for (int k = 0; k < exp_q.size(); k++) begin
         chk({tag, "_state"}, {28'd0, state}, exp_q[k]);
         chk({tag, "_outs"}, {11'd0, dut_out}, {11'd0, expect_out(exp_q[k], ir)});
         chk({tag, "_flags"}, {28'd0, flags}, {28'd0, (k >= 3 && upd) ? nf : mflags});
         @(posedge clk); #1;
      end
      if (upd) mflags = nf;
      chk({tag, "_end_state"}, {28'd0, state}, 32'd0);
      chk({tag, "_end_flags"}, {28'd0, flags}, {28'd0, mflags});
   endtask

   initial begin
      reset = 1'b1; IR = 32'd0; Z = 0; C = 0; N = 0; V = 0;
      mflags = 4'b0000;
      @(posedge clk); #1;
      chk("rst_state", {28'd0, state}, 32'd0);
      chk("rst_flags", {28'd0, flags}, 32'd0);
      chk("rst_outs", {11'd0, dut_out}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      run_instr("add",      32'hE0812003, 0, 0, 0, 0);
      run_instr("bleq_nt",  32'h0B000010, 0, 0, 0, 0);
      run_instr("cmp",      32'hE3510000, 1, 1, 0, 0);
      chk("cmp_flags", {28'd0, flags}, 32'h6);
      run_instr("bleq_t",   32'h0B000010, 0, 0, 0, 0);
      run_instr("ldr",      32'hE5912004, 1, 0, 1, 1);
      run_instr("str",      32'hE5012004, 0, 1, 1, 0);
      run_instr("tst_s",    32'hE1100000, 0, 1, 1, 1);
      run_instr("undef",    32'hEC000000, 1, 1, 1, 1);

      for (int i = 0; i < 200; i++) begin
         run_instr("rnd", $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset aborts a load in MEM_RD: flags must clear and MEM_WB never runs.
      run_instr("cmp2", 32'hE3510000, 1, 1, 0, 0);
      IR = 32'hE5912004; Z = 1; C = 1; N = 1; V = 1;
      #1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
      end
      chk("abort_pre_state", {28'd0, state}, 32'd5);
      reset = 1'b1;
      #1;
      chk("abort_outs_zero", {11'd0, dut_out}, 32'd0);
      @(posedge clk); #1;
      mflags = 4'b0000;
      chk("abort_state", {28'd0, state}, 32'd0);
      chk("abort_flags", {28'd0, flags}, 32'd0);
      chk("abort_outs_held", {11'd0, dut_out}, 32'd0);
      reset = 1'b0;
      run_instr("post_abort", 32'hE0812003, 0, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         run_instr("rnd2", $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
